// File: rtl/flash_audio_reader.sv
// flash_audio_reader
// Playback engine that reads 32-bit words (two 16-bit samples each) from the
// on-board flash over an Avalon-MM read port. It emits one SAMPLE_W-bit sample
// per accepted sample_tick. It walks the clip forward or backward, wrapping at
// both ends, and returns to the clip start when restart is pulsed.
//
// Optional build macro: AUDIO_MUTE_ON_PAUSE_EN
//   defined   : audio_sample is forced to 0 (registered) while pause is high;
//               the next emitted sample overwrites the zero.
//   undefined : audio_sample holds its last value during pause.

module flash_audio_reader #(
    parameter int ADDR_W   = 23,
    parameter int MAX_ADDR = 'h7FFFF,
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pause,
    input  logic                reverse,
    input  logic                restart,
    input  logic                sample_tick,
    output logic                flash_mem_read,
    input  logic                flash_mem_waitrequest,
    output logic [ADDR_W-1:0]   flash_mem_address,
    output logic [3:0]          flash_mem_byteenable,
    input  logic [31:0]         flash_mem_readdata,
    input  logic                flash_mem_readdatavalid,
    output logic [SAMPLE_W-1:0] audio_sample,
    output logic                sample_valid
);

    // Last word address of the clip and the first one, sized to the address bus.
    localparam logic [ADDR_W-1:0] LP_MAX_ADDR = ADDR_W'(MAX_ADDR);
    localparam logic [ADDR_W-1:0] LP_MIN_ADDR = '0;
    localparam logic [ADDR_W-1:0] LP_ONE      = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_FETCH       = 3'd1,
        S_WAIT_VALID  = 3'd2,
        S_EMIT_FIRST  = 3'd3,
        S_WAIT_TICK   = 3'd4,
        S_EMIT_SECOND = 3'd5,
        S_ADVANCE     = 3'd6
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Datapath registers
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_word;
    logic                r_dir;              // half order latched with the word
    logic                r_restart_pending;
    logic [SAMPLE_W-1:0] r_audio_sample;
    logic                r_sample_valid;

    // Control strobes decoded from the current state
    logic w_tick_ok;
    logic w_fetch_read;
    logic w_latch_word;
    logic w_emit_first;
    logic w_emit_second;
    logic w_load_start;      // jump to clip start and consume the pending restart
    logic w_step;            // normal one-word advance

    // Address candidates
    logic [ADDR_W-1:0] w_start_addr;
    logic [ADDR_W-1:0] w_fwd_addr;
    logic [ADDR_W-1:0] w_rev_addr;
    logic [ADDR_W-1:0] w_step_addr;

    // Per-half sample MSBs, index 0 = word[15:0], index 1 = word[31:16]
    logic [SAMPLE_W-1:0] w_half_msbs [2];
    logic [SAMPLE_W-1:0] w_first_sample;
    logic [SAMPLE_W-1:0] w_second_sample;

    // Low bits of each half never reach the output; folded here so they are
    // visibly intentional rather than forgotten.
    logic w_unused;

    assign w_tick_ok = sample_tick & ~pause;

    // ------------------------------------------------------------------
    // Sample extraction
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign w_half_msbs[gi] = r_word[gi*16 + 15 -: SAMPLE_W];
        end

        if (SAMPLE_W < 16) begin : g_unused_low
            assign w_unused = ^{r_word[31-SAMPLE_W:16], r_word[15-SAMPLE_W:0]};
        end else begin : g_no_unused_low
            assign w_unused = 1'b0;
        end
    endgenerate

    // Forward play starts with the low half, backward play with the high half.
    assign w_first_sample  = w_half_msbs[r_dir];
    assign w_second_sample = w_half_msbs[~r_dir];

    // ------------------------------------------------------------------
    // Address arithmetic: start address and wrapped step in either direction.
    // Both use the live reverse level, sampled when the step is taken.
    // ------------------------------------------------------------------
    assign w_start_addr = reverse ? LP_MAX_ADDR : LP_MIN_ADDR;
    assign w_fwd_addr   = (r_addr == LP_MAX_ADDR) ? LP_MIN_ADDR : (r_addr + LP_ONE);
    assign w_rev_addr   = (r_addr == LP_MIN_ADDR) ? LP_MAX_ADDR : (r_addr - LP_ONE);
    assign w_step_addr  = reverse ? w_rev_addr : w_fwd_addr;

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                // A pending restart takes one cycle in IDLE to reload the address.
                if (r_restart_pending) begin
                    w_state_next = S_IDLE;
                end else if (w_tick_ok) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!flash_mem_waitrequest) begin
                    w_state_next = S_WAIT_VALID;
                end
            end
            S_WAIT_VALID: begin
                if (flash_mem_readdatavalid) begin
                    w_state_next = S_EMIT_FIRST;
                end
            end
            S_EMIT_FIRST: begin
                w_state_next = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                // Restart wins over a tick: the second half is dropped.
                if (r_restart_pending) begin
                    w_state_next = S_ADVANCE;
                end else if (w_tick_ok) begin
                    w_state_next = S_EMIT_SECOND;
                end
            end
            S_EMIT_SECOND: begin
                w_state_next = S_ADVANCE;
            end
            S_ADVANCE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: output / control strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_read  = 1'b0;
        w_latch_word  = 1'b0;
        w_emit_first  = 1'b0;
        w_emit_second = 1'b0;
        w_load_start  = 1'b0;
        w_step        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load_start = r_restart_pending;
            end
            S_FETCH: begin
                w_fetch_read = 1'b1;
            end
            S_WAIT_VALID: begin
                w_latch_word = flash_mem_readdatavalid;
            end
            S_EMIT_FIRST: begin
                w_emit_first = 1'b1;
            end
            S_EMIT_SECOND: begin
                w_emit_second = 1'b1;
            end
            S_ADVANCE: begin
                if (r_restart_pending) begin
                    w_load_start = 1'b1;
                end else begin
                    w_step = 1'b1;
                end
            end
            default: begin
                w_fetch_read = 1'b0;
            end
        endcase
    end

    // Word address: reload on restart, otherwise step with wrap after each word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
        end else if (w_load_start) begin
            r_addr <= w_start_addr;
        end else if (w_step) begin
            r_addr <= w_step_addr;
        end
    end

    // Capture returned flash word and freeze the half order for this word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word <= '0;
            r_dir  <= 1'b0;
        end else if (w_latch_word) begin
            r_word <= flash_mem_readdata;
            r_dir  <= reverse;
        end
    end

    // Restart request: set in any state, cleared when consumed unless a new
    // pulse lands in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_restart_pending <= 1'b0;
        end else begin
            r_restart_pending <= restart | (r_restart_pending & ~w_load_start);
        end
    end

    // Output sample register: updated on each emit, optionally muted during pause.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_audio_sample <= '0;
        end else if (w_emit_first) begin
            r_audio_sample <= w_first_sample;
        end else if (w_emit_second) begin
            r_audio_sample <= w_second_sample;
        end
`ifdef AUDIO_MUTE_ON_PAUSE_EN
        else if (pause) begin
            r_audio_sample <= '0;
        end
`endif
    end

    // Valid strobe registered alongside the sample so both change together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= w_emit_first | w_emit_second;
        end
    end

    assign flash_mem_read       = w_fetch_read;
    assign flash_mem_address    = r_addr;
    assign flash_mem_byteenable = 4'hF;
    assign audio_sample         = r_audio_sample;
    assign sample_valid         = r_sample_valid;

endmodule
